if_fetch_unit: RTL and testbench

// Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the PC register, issues word

---
 rtl/if_fetch_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: RV32I fetch stage - PC register, single-outstanding imem requests and a
// small fetch buffer feeding decode. Define IF_MISALIGN_TRAP_EN for misaligned-target traps.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        branch_flush,
   input  logic [31:0] branch_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_data,
   output logic        o_if_valid,
   output logic [31:0] o_if_instr,
   output logic [31:0] o_if_pc,
`ifdef IF_MISALIGN_TRAP_EN
   output logic        o_if_misalign,
`endif
   input  logic        i_id_ready
);

   localparam int          PTR_W     = $clog2(FIFO_DEPTH);
   localparam int          CNT_W     = PTR_W + 1;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
`ifdef IF_MISALIGN_TRAP_EN
      , S_TRAP = 2'd3
`endif
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
`ifdef IF_MISALIGN_TRAP_EN
      logic        misalign;
`endif
   } entry_t;

   state_t             state_q, state_d;
   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic               req_q, req_d;
   logic [31:0]        addr_q, addr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               valid_q, valid_d;
   logic [31:0]        instr_q, instr_d;
   logic [31:0]        pc_q, pc_d;
`ifdef IF_MISALIGN_TRAP_EN
   logic               misalign_q, misalign_d;
   logic               trap_pend_q, trap_pend_d;
   logic [31:0]        trap_pc_q, trap_pc_d;
`else
   logic               unused_pc_lsbs;
   assign unused_pc_lsbs = ^branch_pc[1:0];
`endif

   entry_t             mem_q [FIFO_DEPTH];
   entry_t             wr_entry;
   entry_t             head_d;
   logic               wr_en;
   logic [PTR_W-1:0]   wr_idx;
   logic               ack_take;
   logic               pop;
   logic               flush_drain;

   // NOTE: every signal assigned here gets a default first so no latch can be inferred.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      wr_en      = 1'b0;
      wr_entry   = '0;
`ifdef IF_MISALIGN_TRAP_EN
      trap_pend_d = trap_pend_q;
      trap_pc_d   = trap_pc_q;
`endif
      ack_take    = req_q & i_imem_ack;
      pop         = valid_q & i_id_ready;
      flush_drain = branch_flush & req_q & ~i_imem_ack;

      case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: begin
            if (ack_take) begin
               wr_en          = 1'b1;
               wr_entry.pc    = fetch_pc_q;
               wr_entry.instr = i_imem_data;
               fetch_pc_d     = fetch_pc_q + 32'd4;
            end
         end
         S_DRAIN: begin
            if (ack_take) begin
               state_d = S_FETCH;
`ifdef IF_MISALIGN_TRAP_EN
               if (trap_pend_q) begin
                  wr_en             = 1'b1;
                  wr_entry.pc       = trap_pc_q;
                  wr_entry.instr    = NOP_INSTR;
                  wr_entry.misalign = 1'b1;
                  trap_pend_d       = 1'b0;
                  state_d           = S_TRAP;
               end
`endif
            end
         end
`ifdef IF_MISALIGN_TRAP_EN
         S_TRAP:  state_d = S_TRAP;
`endif
         default: state_d = S_IDLE;
      endcase

      if (!branch_flush) begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
      end else begin
         // Flush kills everything buffered and any word returning this cycle.
         wr_en      = 1'b0;
         wr_entry   = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = {branch_pc[31:2], 2'b00};
         state_d    = flush_drain ? S_DRAIN : S_FETCH;
`ifdef IF_MISALIGN_TRAP_EN
         trap_pend_d = 1'b0;
         if (branch_pc[1:0] != 2'b00) begin
            if (flush_drain) begin
               trap_pend_d = 1'b1;
               trap_pc_d   = branch_pc;
            end else begin
               wr_en             = 1'b1;
               wr_entry.pc       = branch_pc;
               wr_entry.instr    = NOP_INSTR;
               wr_entry.misalign = 1'b1;
               wr_ptr_d          = PTR_W'(1);
               count_d           = CNT_W'(1);
               state_d           = S_TRAP;
            end
         end
`endif
      end

      wr_idx = branch_flush ? '0 : wr_ptr_q;

      // A DRAIN holds the bus on the abandoned address until its ack arrives.
      req_d  = (state_d == S_DRAIN) ||
               ((state_d == S_FETCH) && (count_d < CNT_W'(FIFO_DEPTH)));
      addr_d = (state_d == S_DRAIN) ? addr_q : fetch_pc_d;

      head_d  = (wr_en && (wr_idx == rd_ptr_d)) ? wr_entry : mem_q[rd_ptr_d];
      valid_d = (count_d != '0);
      instr_d = valid_d ? head_d.instr : NOP_INSTR;
      pc_d    = valid_d ? head_d.pc    : 32'h0;
`ifdef IF_MISALIGN_TRAP_EN
      misalign_d = valid_d & head_d.misalign;
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         instr_q    <= NOP_INSTR;
         pc_q       <= 32'h0;
`ifdef IF_MISALIGN_TRAP_EN
         misalign_q  <= 1'b0;
         trap_pend_q <= 1'b0;
         trap_pc_q   <= 32'h0;
`endif
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
`ifdef IF_MISALIGN_TRAP_EN
         misalign_q  <= misalign_d;
         trap_pend_q <= trap_pend_d;
         trap_pc_q   <= trap_pc_d;
`endif
      end
   end

   // NOTE: buffer storage is not reset; count_q alone decides which slots hold live entries.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= wr_entry;
   end

   assign o_imem_req  = req_q;
   assign o_imem_addr = addr_q;
   assign o_if_valid  = valid_q;
   assign o_if_instr  = instr_q;
   assign o_if_pc     = pc_q;
`ifdef IF_MISALIGN_TRAP_EN
   assign o_if_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench for if_fetch_unit with a variable-latency imem model.
module tb_if_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        branch_flush = 1'b0;
   logic [31:0] branch_pc = 32'h0;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack = 1'b0;
   logic [31:0] i_imem_data = 32'h0;
   logic        o_if_valid;
   logic [31:0] o_if_instr;
   logic [31:0] o_if_pc;
   logic        o_if_misalign;
   logic        i_id_ready = 1'b0;

   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];
   logic [31:0] got_pcs[$];
   int          mem_lat = 0;
   int          wait_cnt = 0;
   bit          draining = 1'b0;
   bit          trap_pend = 1'b0;
   bit          prev_pending = 1'b0;
   logic [31:0] drain_addr = 32'h0;
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] trap_pc = 32'h0;
   logic [31:0] prev_addr = 32'h0;

   if_fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .branch_flush  (branch_flush),
      .branch_pc     (branch_pc),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_ack    (i_imem_ack),
      .i_imem_data   (i_imem_data),
      .o_if_valid    (o_if_valid),
      .o_if_instr    (o_if_instr),
      .o_if_pc       (o_if_pc),
`ifdef IF_MISALIGN_TRAP_EN
      .o_if_misalign (o_if_misalign),
`endif
      .i_id_ready    (i_id_ready)
   );

`ifndef IF_MISALIGN_TRAP_EN
   assign o_if_misalign = 1'b0;
`endif

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return addr * 32'h9E37_79B9 + 32'h0000_1234;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #3;
      rst_n        = 1'b0;
      branch_flush = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      got_pcs.delete();
   endtask

   task automatic do_flush(input logic [31:0] target);
      branch_flush = 1'b1;
      branch_pc    = target;
      tick();
      branch_flush = 1'b0;
   endtask

   // Memory responder and decode-side scoreboard, evaluated mid-cycle on the falling edge.
   task automatic monitor_loop();
      exp_t e;
      bit   ack_now;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb.delete();
            exp_pc       = 32'h0;
            draining     = 1'b0;
            trap_pend    = 1'b0;
            wait_cnt     = 0;
            prev_pending = 1'b0;
            i_imem_ack   = 1'b0;
            continue;
         end
         if (!branch_flush && o_if_valid && i_id_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL deliver_extra: got pc=%h instr=%h, expected no entry", o_if_pc, o_if_instr);
            end else begin
               e = sb.pop_front();
               if (o_if_pc !== e.pc || o_if_instr !== e.instr || o_if_misalign !== e.mis) begin
                  errors++;
                  $display("FAIL deliver: got pc=%h instr=%h mis=%b, expected pc=%h instr=%h mis=%b",
                           o_if_pc, o_if_instr, o_if_misalign, e.pc, e.instr, e.mis);
               end
            end
            got_pcs.push_back(o_if_pc);
         end
         if (!o_if_valid) begin
            checks++;
            if (o_if_instr !== NOP) begin
               errors++;
               $display("FAIL empty_nop: got instr=%h, expected %h", o_if_instr, NOP);
            end
         end
         ack_now = 1'b0;
         if (o_imem_req) begin
            if (prev_pending) begin
               checks++;
               if (o_imem_addr !== prev_addr) begin
                  errors++;
                  $display("FAIL addr_hold: got addr=%h, expected %h", o_imem_addr, prev_addr);
               end
            end
            if (wait_cnt >= mem_lat) begin
               ack_now  = 1'b1;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
         prev_pending = o_imem_req && !ack_now;
         prev_addr    = o_imem_addr;
         i_imem_ack   = ack_now;
         i_imem_data  = ack_now ? mem_word(o_imem_addr) : 32'hDEAD_BEEF;
         if (ack_now) begin
            checks++;
            if (o_imem_addr !== (draining ? drain_addr : exp_pc)) begin
               errors++;
               $display("FAIL req_addr: got addr=%h, expected %h", o_imem_addr, draining ? drain_addr : exp_pc);
            end
            if (!branch_flush && !draining) begin
               e.pc    = exp_pc;
               e.instr = mem_word(exp_pc);
               e.mis   = 1'b0;
               sb.push_back(e);
               exp_pc += 32'd4;
            end
         end
         if (branch_flush) begin
            sb.delete();
            if (o_imem_req && !ack_now) begin
               if (!draining) drain_addr = o_imem_addr;
               draining = 1'b1;
            end else begin
               draining = 1'b0;
            end
            exp_pc = {branch_pc[31:2], 2'b00};
`ifdef IF_MISALIGN_TRAP_EN
            trap_pend = 1'b0;
            if (branch_pc[1:0] != 2'b00) begin
               if (draining) begin
                  trap_pend = 1'b1;
                  trap_pc   = branch_pc;
               end else begin
                  e.pc    = branch_pc;
                  e.instr = NOP;
                  e.mis   = 1'b1;
                  sb.push_back(e);
               end
            end
`endif
         end else if (ack_now && draining) begin
            draining = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            if (trap_pend) begin
               e.pc      = trap_pc;
               e.instr   = NOP;
               e.mis     = 1'b1;
               sb.push_back(e);
               trap_pend = 1'b0;
            end
`endif
         end
      end
   endtask

   task automatic test_reset();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (o_imem_req !== 1'b0 || o_if_valid !== 1'b0 || o_if_instr !== NOP ||
          o_if_pc !== 32'h0 || o_if_misalign !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got req=%b valid=%b instr=%h pc=%h mis=%b, expected 0 0 %h 0 0",
                  o_imem_req, o_if_valid, o_if_instr, o_if_pc, o_if_misalign, NOP);
      end
   endtask

   task automatic test_back_to_back();
      int gaps = 0;
      int n;
      mem_lat    = 0;
      i_id_ready = 1'b1;
      apply_reset();
      tick();
      checks++;
      if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL first_req: got req=%b addr=%h, expected 1 00000000", o_imem_req, o_imem_addr);
      end
      for (n = 0; n < 5 && !o_if_valid; n++) tick();
      repeat (10) begin
         tick();
         if (!o_if_valid) gaps++;
      end
      checks++;
      if (gaps != 0) begin
         errors++;
         $display("FAIL b2b_gaps: got %0d empty cycles, expected 0", gaps);
      end
      checks++;
      if (got_pcs.size() < 8) begin
         errors++;
         $display("FAIL b2b_count: got %0d delivered, expected at least 8", got_pcs.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (got_pcs[i] !== 32'(4 * i)) begin
               errors++;
               $display("FAIL b2b_order: got pc=%h at %0d, expected %h", got_pcs[i], i, 32'(4 * i));
               break;
            end
         end
      end
   endtask

   task automatic test_backpressure();
      mem_lat    = 0;
      i_id_ready = 1'b0;
      apply_reset();
      repeat (6) tick();
      checks++;
      if (o_imem_req !== 1'b0 || o_if_valid !== 1'b1 || o_if_pc !== 32'h0 || sb.size() != 2) begin
         errors++;
         $display("FAIL bp_full: got req=%b valid=%b pc=%h buffered=%0d, expected 0 1 00000000 2",
                  o_imem_req, o_if_valid, o_if_pc, sb.size());
      end
      i_id_ready = 1'b1;
      repeat (8) tick();
      checks++;
      if (got_pcs.size() < 3 || got_pcs[0] !== 32'h0 || got_pcs[1] !== 32'h4 || got_pcs[2] !== 32'h8) begin
         errors++;
         $display("FAIL bp_release: got %0d entries starting pc=%h, expected 00000000,4,8",
                  got_pcs.size(), got_pcs.size() > 0 ? got_pcs[0] : 32'hX);
      end
      checks++;
      for (int i = 1; i < got_pcs.size(); i++) begin
         if (got_pcs[i] !== got_pcs[i-1] + 32'd4) begin
            errors++;
            $display("FAIL bp_seq: got pc=%h after %h, expected %h", got_pcs[i], got_pcs[i-1], got_pcs[i-1] + 32'd4);
            break;
         end
      end
   endtask

   task automatic test_flush_buffered();
      mem_lat    = 0;
      i_id_ready = 1'b0;
      apply_reset();
      tick();
      do_flush(32'h10);
      repeat (5) tick();
      checks++;
      if (o_if_valid !== 1'b1 || o_if_pc !== 32'h10 || sb.size() != 2 || o_imem_req !== 1'b0) begin
         errors++;
         $display("FAIL flush_fill: got valid=%b pc=%h buffered=%0d req=%b, expected 1 00000010 2 0",
                  o_if_valid, o_if_pc, sb.size(), o_imem_req);
      end
      do_flush(32'h40);
      checks++;
      if (o_if_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_clear: got valid=%b, expected 0", o_if_valid);
      end
      i_id_ready = 1'b1;
      repeat (8) tick();
      checks++;
      if (got_pcs.size() < 2 || got_pcs[0] !== 32'h40 || got_pcs[1] !== 32'h44) begin
         errors++;
         $display("FAIL flush_target: got %0d entries starting pc=%h, expected 00000040,44",
                  got_pcs.size(), got_pcs.size() > 0 ? got_pcs[0] : 32'hX);
      end
   endtask

   task automatic test_flush_drain();
      int n;
      int bad = 0;
      mem_lat    = 3;
      i_id_ready = 1'b1;
      apply_reset();
      for (n = 0; n < 10 && !(o_imem_req && wait_cnt == 1); n++) tick();
      checks++;
      if (!(o_imem_req && wait_cnt == 1) || o_imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL drain_setup: got req=%b waited=%0d addr=%h, expected 1 1 00000000",
                  o_imem_req, wait_cnt, o_imem_addr);
      end
      do_flush(32'h80);
      for (n = 0; n < 10 && draining; n++) begin
         if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) bad++;
         tick();
      end
      checks++;
      if (draining || bad != 0) begin
         errors++;
         $display("FAIL drain_hold: got still_draining=%b bad_cycles=%0d, expected 0 0", draining, bad);
      end
      checks++;
      if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h80) begin
         errors++;
         $display("FAIL drain_next: got req=%b addr=%h, expected 1 00000080", o_imem_req, o_imem_addr);
      end
      for (n = 0; n < 40 && got_pcs.size() < 2; n++) tick();
      checks++;
      if (got_pcs.size() < 2 || got_pcs[0] !== 32'h80 || got_pcs[1] !== 32'h84) begin
         errors++;
         $display("FAIL drain_target: got %0d entries starting pc=%h, expected 00000080,84",
                  got_pcs.size(), got_pcs.size() > 0 ? got_pcs[0] : 32'hX);
      end
   endtask

   task automatic test_flush_with_ack();
      int n;
      int idx;
      bit seen8 = 1'b0;
      mem_lat    = 0;
      i_id_ready = 1'b1;
      apply_reset();
      for (n = 0; n < 10 && !(o_imem_req && o_imem_addr == 32'h8); n++) tick();
      idx = got_pcs.size();
      do_flush(32'h20);
      repeat (6) tick();
      foreach (got_pcs[i]) if (got_pcs[i] == 32'h8) seen8 = 1'b1;
      checks++;
      if (got_pcs.size() <= idx || got_pcs[idx] !== 32'h20 || seen8) begin
         errors++;
         $display("FAIL flush_ack: got next pc=%h saw_8=%b, expected 00000020 0",
                  got_pcs.size() > idx ? got_pcs[idx] : 32'hX, seen8);
      end
   endtask

   task automatic test_misaligned();
      int idx;
      mem_lat    = 0;
      i_id_ready = 1'b1;
      apply_reset();
      repeat (3) tick();
      idx = got_pcs.size();
      do_flush(32'h06);
`ifdef IF_MISALIGN_TRAP_EN
      begin
         int req_high = 0;
         repeat (6) begin
            if (o_imem_req) req_high++;
            tick();
         end
         checks++;
         if (req_high != 0 || got_pcs.size() != idx + 1 || got_pcs[idx] !== 32'h06) begin
            errors++;
            $display("FAIL trap_entry: got req_cycles=%0d entries=%0d pc=%h, expected 0 1 00000006",
                     req_high, got_pcs.size() - idx, got_pcs.size() > idx ? got_pcs[idx] : 32'hX);
         end
         do_flush(32'h100);
         repeat (4) tick();
         checks++;
         if (got_pcs.size() < idx + 2 || got_pcs[idx+1] !== 32'h100) begin
            errors++;
            $display("FAIL trap_exit: got pc=%h, expected 00000100",
                     got_pcs.size() > idx + 1 ? got_pcs[idx+1] : 32'hX);
         end
      end
`else
      checks++;
      if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h4) begin
         errors++;
         $display("FAIL misalign_addr: got req=%b addr=%h, expected 1 00000004", o_imem_req, o_imem_addr);
      end
      repeat (6) tick();
      checks++;
      if (got_pcs.size() < idx + 2 || got_pcs[idx] !== 32'h4 || got_pcs[idx+1] !== 32'h8) begin
         errors++;
         $display("FAIL misalign_forced: got pc=%h, expected 00000004 then 8",
                  got_pcs.size() > idx ? got_pcs[idx] : 32'hX);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int n;
      mem_lat    = 3;
      i_id_ready = 1'b1;
      apply_reset();
      for (n = 0; n < 10 && !(o_imem_req && wait_cnt == 1); n++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (o_imem_req !== 1'b0 || o_if_valid !== 1'b0 || o_if_instr !== NOP || o_if_pc !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset: got req=%b valid=%b instr=%h pc=%h, expected 0 0 %h 0",
                  o_imem_req, o_if_valid, o_if_instr, o_if_pc, NOP);
      end
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      got_pcs.delete();
      for (n = 0; n < 30 && got_pcs.size() < 1; n++) tick();
      checks++;
      if (got_pcs.size() < 1 || got_pcs[0] !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset_restart: got pc=%h, expected 00000000",
                  got_pcs.size() > 0 ? got_pcs[0] : 32'hX);
      end
   endtask

   initial begin
      fork
         monitor_loop();
      join_none
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_flush_buffered();
      test_flush_drain();
      test_flush_with_ack();
      test_misaligned();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
